// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed scan driver for a common-anode 7-segment display.
// Double-buffered frame updates, per-slot anode guard, leading-zero blanking.
module seg7_scan_driver #(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned GUARD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        dp,
    output logic [1:0]  pos
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic [15:0]   sh_val;
    logic [3:0]    sh_dp;
    logic          pending;
    logic [15:0]   dsp_val;
    logic [3:0]    dsp_dp;

    logic          tick;
    logic          commit;
    logic          in_guard;
    logic [3:0]    blanked;
    logic          lit;

    assign tick   = (cnt == CW'(DIV - 1));
    assign commit = tick && (pos == 2'd3) && pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            pos <= '0;
        end else if (tick) begin
            cnt <= '0;
            pos <= pos + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // A load in the commit cycle wins over the clear, so it lands next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_val  <= '0;
            sh_dp   <= '0;
            pending <= 1'b0;
            dsp_val <= '0;
            dsp_dp  <= '0;
        end else begin
            if (commit) begin
                dsp_val <= sh_val;
                dsp_dp  <= sh_dp;
            end
            if (load) begin
                sh_val  <= value;
                sh_dp   <= dp_in;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    generate
        if (GUARD == 0) begin : g_noguard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (cnt < CW'(GUARD));
        end
    endgenerate

    always_comb begin
        blanked    = 4'b0000;
        blanked[3] = blank_lz && (dsp_val[15:12] == 4'h0);
        blanked[2] = blanked[3] && (dsp_val[11:8] == 4'h0);
        blanked[1] = blanked[2] && (dsp_val[7:4] == 4'h0);
    end

    assign lit   = !in_guard && !blanked[pos];
    assign digit = dsp_val[{pos, 2'b00} +: 4];
    assign an    = lit ? ~(4'b0001 << pos) : 4'b1111;
    assign dp    = lit ? ~dsp_dp[pos] : 1'b1;

endmodule
